// File: rtl/seq_divider_if.sv
// Request/result bundle for seq_divider: host drives operands and start,
// divider returns status and results.
interface seq_divider_if;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;
  logic       ovf;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero, ovf
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero, ovf
  );
endinterface

// File: rtl/seq_divider.sv
// 8-bit / 4-bit restoring divider, one quotient bit per clock, MSB first.
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands (magnitude divide + sign fix-up).
module seq_divider (
  input  logic          clk,
  input  logic          rst,
  seq_divider_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t     state, state_nx;
  logic [2:0] cnt;
  logic [3:0] rem;
  logic [7:0] dq;
  logic [3:0] dvs;
  logic       qneg, rneg;
  logic [7:0] quot_r;
  logic [3:0] rem_r;
  logic       dbz_r;

  logic [7:0] a_mag;
  logic [3:0] b_mag;
  logic       qneg_in, rneg_in;
  logic [4:0] trial;
  logic       ge;
  logic [3:0] rem_nx;
  logic [7:0] q_nx;
  logic [7:0] q_fin;
  logic [3:0] r_fin;

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic ovf_in, ovf_pend, ovf_r;

  // -128 magnitude is 8'h80, which still fits the unsigned datapath
  assign a_mag   = bus.dividend[7] ? (~bus.dividend + 8'd1) : bus.dividend;
  assign b_mag   = bus.divisor[3]  ? (~bus.divisor + 4'd1)  : bus.divisor;
  assign qneg_in = bus.dividend[7] ^ bus.divisor[3];
  assign rneg_in = bus.dividend[7];
  assign ovf_in  = (bus.dividend == 8'h80) && (bus.divisor == 4'hF);
  assign bus.ovf = ovf_r;
`else
  assign a_mag   = bus.dividend;
  assign b_mag   = bus.divisor;
  assign qneg_in = 1'b0;
  assign rneg_in = 1'b0;
  assign bus.ovf = 1'b0;
`endif

  // partial remainder stays below the divisor, so 4 bits plus the shifted-in bit suffice
  assign trial  = {rem, dq[7]};
  assign ge     = trial >= {1'b0, dvs};
  assign rem_nx = ge ? (trial[3:0] - dvs) : trial[3:0];
  assign q_nx   = {dq[6:0], ge};
  assign q_fin  = qneg ? (~q_nx + 8'd1) : q_nx;
  assign r_fin  = rneg ? (~rem_nx + 4'd1) : rem_nx;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = (bus.divisor == 4'd0) ? DONE : CALC;
      CALC:    if (cnt == 3'd7) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      rem    <= '0;
      dq     <= '0;
      dvs    <= '0;
      qneg   <= 1'b0;
      rneg   <= 1'b0;
      quot_r <= '0;
      rem_r  <= '0;
      dbz_r  <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      ovf_pend <= 1'b0;
      ovf_r    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          if (bus.divisor == 4'd0) begin
            quot_r <= 8'hFF;
            rem_r  <= bus.dividend[3:0];
            dbz_r  <= 1'b1;
`ifdef SEQ_DIVIDER_SIGNED_EN
            ovf_r  <= 1'b0;
`endif
          end else begin
            cnt  <= '0;
            rem  <= '0;
            dq   <= a_mag;
            dvs  <= b_mag;
            qneg <= qneg_in;
            rneg <= rneg_in;
`ifdef SEQ_DIVIDER_SIGNED_EN
            ovf_pend <= ovf_in;
`endif
          end
        end
        CALC: begin
          cnt <= cnt + 3'd1;
          dq  <= q_nx;
          rem <= rem_nx;
          // results are published on the same edge that enters DONE
          if (cnt == 3'd7) begin
            quot_r <= q_fin;
            rem_r  <= r_fin;
            dbz_r  <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            ovf_r  <= ovf_pend;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = (state != IDLE);
  assign bus.done        = (state == DONE);
  assign bus.quotient    = quot_r;
  assign bus.remainder   = rem_r;
  assign bus.div_by_zero = dbz_r;
endmodule

// File: tb/tb_seq_divider.sv
// Directed + random checks of seq_divider against an arithmetic reference model.
module tb_seq_divider;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nvec = 0;
  int   nerr = 0;

  seq_divider_if ifc();
  seq_divider dut (.clk(clk), .rst(rst), .bus(ifc));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division; SV int / and % truncate toward zero, remainder follows dividend.
  task automatic model(input logic [7:0] a, input logic [3:0] b,
                       output logic [7:0] eq, output logic [3:0] er,
                       output logic edz, output logic eov);
    int sa, sb, q, r;
`ifdef SEQ_DIVIDER_SIGNED_EN
    sa = $signed(a);
    sb = $signed(b);
`else
    sa = int'(a);
    sb = int'(b);
`endif
    if (b == 4'd0) begin
      eq = 8'hFF; er = a[3:0]; edz = 1'b1; eov = 1'b0;
    end else begin
      q = sa / sb;
      r = sa % sb;
      eq = q[7:0]; er = r[3:0]; edz = 1'b0;
      eov = (sa == -128) && (sb == -1);
    end
  endtask

  task automatic watch_no_done(input string tag, input int cycles);
    int pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (ifc.done === 1'b1) pulses++;
    end
    chk(tag, pulses, 0);
  endtask

  task automatic do_div(input logic [7:0] a, input logic [3:0] b, input bit pulse_mid);
    logic [7:0] eq;
    logic [3:0] er;
    logic       edz, eov;
    int         lat;
    model(a, b, eq, er, edz, eov);
    @(negedge clk);
    rst = 1'b0;
    ifc.start = 1'b1; ifc.dividend = a; ifc.divisor = b;
    @(posedge clk); #1;
    ifc.start = 1'b0;
    ifc.dividend = 8'($urandom);
    ifc.divisor  = 4'($urandom);
    lat = 0;
    while (ifc.done !== 1'b1 && lat < 20) begin
      chk("busy_calc", ifc.busy, 1);
      if (pulse_mid && lat == 2) ifc.start = 1'b1;
      if (pulse_mid && lat == 3) ifc.start = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, (b == 4'd0) ? 0 : 8);
    chk("busy_done", ifc.busy, 1);
    chk("quotient", ifc.quotient, eq);
    chk("remainder", ifc.remainder, er);
    chk("div_by_zero", ifc.div_by_zero, edz);
`ifdef SEQ_DIVIDER_SIGNED_EN
    chk("ovf", ifc.ovf, eov);
`else
    chk("ovf", ifc.ovf, 0);
`endif
    @(posedge clk); #1;
    chk("done_one_cycle", ifc.done, 0);
    chk("idle_busy", ifc.busy, 0);
    chk("quotient_hold", ifc.quotient, eq);
    chk("remainder_hold", ifc.remainder, er);
    if (pulse_mid) watch_no_done("start_ignored", 12);
  endtask

  initial begin
    ifc.start = 1'b0; ifc.dividend = 8'd0; ifc.divisor = 4'd0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    ifc.start = 1'b1; ifc.dividend = 8'd77; ifc.divisor = 4'd3;
    @(posedge clk); #1;
    chk("rst_busy", ifc.busy, 0);
    chk("rst_done", ifc.done, 0);
    chk("rst_quotient", ifc.quotient, 0);
    chk("rst_remainder", ifc.remainder, 0);
    chk("rst_dbz", ifc.div_by_zero, 0);
    chk("rst_ovf", ifc.ovf, 0);
    ifc.start = 1'b0;

    // first edge with rst low accepts
    do_div(8'd100, 4'd7, 1'b0);
`ifndef SEQ_DIVIDER_SIGNED_EN
    chk("u100_7_q", ifc.quotient, 14);
    chk("u100_7_r", ifc.remainder, 2);
`endif
    do_div(8'd255, 4'd15, 1'b1);
`ifndef SEQ_DIVIDER_SIGNED_EN
    chk("u255_15_q", ifc.quotient, 17);
    chk("u255_15_r", ifc.remainder, 0);
`endif
    do_div(8'h2A, 4'd0, 1'b0);
    chk("dz_q", ifc.quotient, 8'hFF);
    chk("dz_r", ifc.remainder, 4'hA);
    chk("dz_flag", ifc.div_by_zero, 1);

`ifdef SEQ_DIVIDER_SIGNED_EN
    do_div(8'h9C, 4'd7, 1'b0);
    chk("s_m100_7_q", ifc.quotient, 8'hF2);
    chk("s_m100_7_r", ifc.remainder, 4'hE);
    do_div(8'd100, 4'h9, 1'b0);
    chk("s_100_m7_q", ifc.quotient, 8'hF2);
    chk("s_100_m7_r", ifc.remainder, 4'h2);
    do_div(8'h80, 4'hF, 1'b0);
    chk("s_ovf_q", ifc.quotient, 8'h80);
    chk("s_ovf_r", ifc.remainder, 0);
    chk("s_ovf_flag", ifc.ovf, 1);
    do_div(8'd50, 4'd5, 1'b0);
    chk("s_ovf_clear", ifc.ovf, 0);
`endif

    // abort 200/3 with reset on the 4th CALC edge
    @(negedge clk);
    ifc.start = 1'b1; ifc.dividend = 8'd200; ifc.divisor = 4'd3;
    @(posedge clk); #1;
    ifc.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", ifc.busy, 0);
    chk("abort_done", ifc.done, 0);
    chk("abort_quotient", ifc.quotient, 0);
    chk("abort_remainder", ifc.remainder, 0);
    chk("abort_dbz", ifc.div_by_zero, 0);
    chk("abort_ovf", ifc.ovf, 0);
    watch_no_done("abort_no_done", 12);
    do_div(8'd9, 4'd2, 1'b0);
    chk("after_abort_q", ifc.quotient, 4);
    chk("after_abort_r", ifc.remainder, 1);

    for (int i = 0; i < 40; i++) begin
      do_div(8'($urandom), 4'($urandom), (i % 7) == 3);
    end
    do_div(8'd0, 4'd1, 1'b0);
    do_div(8'hFF, 4'd1, 1'b0);
    do_div(8'h0F, 4'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
